// File: rtl/boot_pkg.sv
// Purpose: shared types and constants for the boot image loader (FSM states, frame fields).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package boot_pkg;

  // Parser states. Only DONE and ERROR stop fetching bytes from the FIFO.
  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } boot_state_e;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Frame field geometry.
  localparam int BYTE_W     = 8;   // FIFO byte width
  localparam int LEN_W      = 16;  // word-count field width (LEN_LO + LEN_HI)
  localparam int WORD_W     = 32;  // IMEM word width
  localparam int WORD_BYTES = 4;   // payload bytes packed per IMEM word

  // States in which the parser wants another byte from the FIFO.
  function automatic logic is_fetch_state(input boot_state_e s);
    return (s == IDLE) || (s == LEN_LO) || (s == LEN_HI) ||
           (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/boot_byte_fetch.sv
// Purpose: one-read-in-flight handshake on the async byte FIFO read port.
// Latency: byte_vld one cycle after the accepted fifo_rd_en; at most 1 byte per 2 cycles.
// Backpressure: no read while fifo_empty, while a read is pending, or while fetch_en is low.
//
// Ports:
//   clk, rst_n          core clock, async active-low reset
//   fetch_en            parser is in a state that consumes bytes
//   clr                 drop any pending read (parser re-entering IDLE)
//   fifo_empty          FIFO empty flag
//   fifo_rd_data        FIFO data, valid the cycle after an accepted read
//   fifo_rd_en          FIFO read strobe
//   byte_dat, byte_vld  captured byte to the parser
module boot_byte_fetch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fetch_en,
  input  logic       clr,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  output logic [7:0] byte_dat,
  output logic       byte_vld
);

  // armed keeps the read strobe low while reset is held and for the first
  // clock after release, so fifo_rd_en is 0 regardless of fifo_empty in reset.
  logic armed;
  logic pending;

  assign fifo_rd_en = armed && fetch_en && !fifo_empty && !pending;

  // The byte for a read issued last cycle is on fifo_rd_data now.
  assign byte_vld = pending;
  assign byte_dat = fifo_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      pending <= 1'b0;
    end else begin
      armed <= 1'b1;
      // rd_en is never high while pending, so this also clears pending
      // on the capture cycle.
      if (clr) begin
        pending <= 1'b0;
      end else begin
        pending <= fifo_rd_en;
      end
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Purpose: parse a framed boot image from the byte FIFO, pack payload into IMEM words, release CPU reset on good checksum.
// Latency: imem_we 1 cycle after the 4th byte of a word is captured; DONE/ERROR 1 cycle after the deciding byte.
// Backpressure: a starved FIFO stalls the parser; no FIFO reads in DONE/ERROR until restart.
//
// Ports:
//   clk, rst_n                      core clock, async active-low reset
//   fifo_empty, fifo_rd_en,
//   fifo_rd_data                    FIFO read port (data valid the cycle after a read)
//   restart                         pulse: DONE/ERROR -> IDLE, ignored elsewhere
//   imem_we, imem_addr, imem_wdata  IMEM word write port
//   cpu_rst_n                       core reset, released only in DONE
//   done, error                     frame accepted / rejected
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int         ADDR_WIDTH = 12,
  parameter int         BASE_ADDR  = 0,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [7:0]            fifo_rd_data,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_W-1:0]     imem_wdata,
  output logic                  cpu_rst_n,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  boot_state_e       state;
  logic [BYTE_W-1:0] len_lo_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic [BYTE_W-1:0] csum;
  logic [23:0]       wbuf;      // lanes 0..2 of the word being assembled
  logic              done_q;
  logic              error_q;

  logic [BYTE_W-1:0] byte_dat;
  logic              byte_vld;
  logic              leave_end;

  logic [LEN_W-1:0]  len_rx;
  logic [31:0]       len_rx_ext;
  logic [31:0]       addr_sum;

  // restart only has effect from the terminal states
  assign leave_end = restart && ((state == DONE) || (state == ERROR));

  boot_byte_fetch u_fetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en     (is_fetch_state(state)),
    .clr          (leave_end),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .byte_dat     (byte_dat),
    .byte_vld     (byte_vld)
  );

  assign len_rx     = {byte_dat, len_lo_q};
  assign len_rx_ext = {16'd0, len_rx};
  // IMEM address wraps modulo 2**ADDR_WIDTH via truncation.
  assign addr_sum   = 32'(BASE_ADDR) + {16'd0, word_idx};

  assign done      = done_q;
  assign error     = error_q;
  assign cpu_rst_n = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx   <= '0;
      lane       <= '0;
      csum       <= '0;
      wbuf       <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          // Anything other than the marker is line noise; drop it.
          if (byte_vld && (byte_dat == SYNC_BYTE)) begin
            state <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (byte_vld) begin
            len_lo_q <= byte_dat;
            csum     <= csum + byte_dat;
            state    <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (byte_vld) begin
            len_q <= len_rx;
            csum  <= csum + byte_dat;
            if (len_rx == '0) begin
              state <= CSUM;
            end else if (len_rx_ext > MAX_WORDS) begin
              state   <= ERROR;
              error_q <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (byte_vld) begin
            csum <= csum + byte_dat;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: wbuf[7:0]   <= byte_dat;
              2'd1: wbuf[15:8]  <= byte_dat;
              2'd2: wbuf[23:16] <= byte_dat;
              default: begin
                // Lane 3 completes the word; write it out next cycle.
                imem_we    <= 1'b1;
                imem_addr  <= addr_sum[ADDR_WIDTH-1:0];
                imem_wdata <= {byte_dat, wbuf};
                word_idx   <= word_idx + 16'd1;
                if (word_idx == (len_q - 16'd1)) begin
                  state <= CSUM;
                end
              end
            endcase
          end
        end

        CSUM: begin
          if (byte_vld) begin
            if (byte_dat == csum) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= ERROR;
              error_q <= 1'b1;
            end
          end
        end

        DONE, ERROR: begin
          if (restart) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            word_idx <= '0;
            lane     <= '0;
            csum     <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
